// File: rtl/adc_multi_capture_if.sv
// Packet read port of adc_multi_capture.
// rd_req_p/rd_ack_p handshake, head packet, FIFO flags, overflow count.
interface adc_multi_capture_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16
);
  localparam int PKT_W = 8 + NUM_CH * DATA_W;

  logic             rd_req_p;
  logic             rd_ack_p;
  logic [PKT_W-1:0] data_packet_p;
  logic             fifo_empty_p;
  logic             fifo_full_p;
  logic [7:0]       overflow_cnt_p;

  modport master (
    output rd_req_p,
    input  rd_ack_p,
    input  data_packet_p,
    input  fifo_empty_p,
    input  fifo_full_p,
    input  overflow_cnt_p
  );

  modport slave (
    input  rd_req_p,
    output rd_ack_p,
    output data_packet_p,
    output fifo_empty_p,
    output fifo_full_p,
    output overflow_cnt_p
  );
endinterface

// File: rtl/adc_multi_capture.sv
// Multi-channel serial ADC capture: cnv/sck sequencing, packet FIFO.
// Ports: clk210_p, reset_p, control inputs, sdo_p in, cnv_p/sck_p/busy_p out, rd_if read port.
module adc_multi_capture #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 16,
  parameter int SCK_DIV    = 2,
  parameter int CONV_CYC   = 150,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk210_p,
  input  logic              reset_p,
  input  logic              enable_p,
  input  logic              continuous_p,
  input  logic              trigger_p,
  input  logic [15:0]       sample_period_p,
  input  logic [NUM_CH-1:0] sdo_p,
  output logic              cnv_p,
  output logic              sck_p,
  output logic              busy_p,
  adc_multi_capture_if.slave rd_if
);
  localparam int PKT_W = 8 + NUM_CH * DATA_W;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(CONV_CYC) + 1;
  localparam int PW    = $clog2(2 * SCK_DIV) + 1;
  localparam int BW    = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_SHIFT, S_STORE, S_WAIT
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [CW-1:0] r_ccnt;
  logic [PW-1:0] r_ph;
  logic [BW-1:0] r_bit;
  logic [15:0]   r_since;
  logic          r_cnv;
  logic          r_sck;
  logic [NUM_CH-1:0][DATA_W-1:0] r_sh;

  logic [PKT_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             r_ack;
  logic [PKT_W-1:0] r_dout;
  logic [7:0]       r_seq;
  logic [7:0]       r_ovf;

  logic w_conv_done;
  logic w_ph_last;
  logic w_sample;
  logic w_shift_done;
  logic w_elapsed;
  logic w_start;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_store;

  assign w_conv_done  = r_ccnt == CW'(CONV_CYC - 1);
  assign w_ph_last    = r_ph == PW'(2 * SCK_DIV - 1);
  assign w_sample     = (r_state == S_SHIFT) && (r_ph == PW'(SCK_DIV - 1));
  assign w_shift_done = w_ph_last && (r_bit == BW'(DATA_W - 1));
  // r_since counts edges since the last cnv_p rise; one more edge lands on it
  assign w_elapsed    = (17'(r_since) + 17'd1) >= 17'(sample_period_p);
  assign w_start      = (w_nxt == S_CONV) && (r_state != S_CONV);

  assign w_empty = r_cnt == '0;
  assign w_full  = r_cnt == (AW+1)'(FIFO_DEPTH);
  // r_ack gating gives one pop per two cycles under a held request
  assign w_pop   = rd_if.rd_req_p && !w_empty && !r_ack;
  assign w_store = r_state == S_STORE;
  assign w_push  = w_store && (!w_full || w_pop);

  always_ff @(posedge clk210_p) begin
    if (reset_p) r_state <= S_IDLE;
    else         r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (enable_p && (continuous_p || trigger_p)) w_nxt = S_CONV;
      S_CONV:  if (w_conv_done) w_nxt = S_SHIFT;
      S_SHIFT: if (w_shift_done) w_nxt = S_STORE;
      S_STORE: begin
        if (continuous_p && enable_p) w_nxt = w_elapsed ? S_CONV : S_WAIT;
        else                          w_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (!enable_p)     w_nxt = S_IDLE;
        else if (w_elapsed) w_nxt = S_CONV;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      r_ccnt  <= '0;
      r_ph    <= '0;
      r_bit   <= '0;
      r_since <= '0;
      r_cnv   <= 1'b0;
      r_sck   <= 1'b0;
      r_sh    <= '0;
    end else begin
      r_cnv  <= w_nxt == S_CONV;
      r_ccnt <= (r_state == S_CONV) ? r_ccnt + 1'b1 : '0;
      if (r_state == S_SHIFT) begin
        r_ph <= w_ph_last ? '0 : r_ph + 1'b1;
        if (w_ph_last) r_bit <= r_bit + 1'b1;
      end else begin
        r_ph  <= '0;
        r_bit <= '0;
      end
      if (w_sample)                              r_sck <= 1'b1;
      else if (r_state != S_SHIFT || w_ph_last) r_sck <= 1'b0;
      if (w_sample) begin
        for (int i = 0; i < NUM_CH; i++)
          r_sh[i] <= {r_sh[i][DATA_W-2:0], sdo_p[i]};
      end
      if (w_start)              r_since <= '0;
      else if (r_since != '1)   r_since <= r_since + 1'b1;
    end
  end

  always_ff @(posedge clk210_p) begin
    if (w_push) r_mem[r_wp] <= {r_seq, r_sh};
  end

  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_ack  <= 1'b0;
      r_dout <= '0;
      r_seq  <= '0;
      r_ovf  <= '0;
    end else begin
      r_ack <= w_pop;
      if (w_pop) begin
        r_dout <= r_mem[r_rp];
        r_rp   <= r_rp + 1'b1;
      end
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      if (w_store) begin
        r_seq <= r_seq + 1'b1;
        if (!w_push && r_ovf != 8'hFF) r_ovf <= r_ovf + 1'b1;
      end
    end
  end

  assign cnv_p                = r_cnv;
  assign sck_p                = r_sck;
  assign busy_p               = r_state != S_IDLE;
  assign rd_if.rd_ack_p       = r_ack;
  assign rd_if.data_packet_p  = r_dout;
  assign rd_if.fifo_empty_p   = w_empty;
  assign rd_if.fifo_full_p    = w_full;
  assign rd_if.overflow_cnt_p = r_ovf;
endmodule

// File: tb/tb_adc_multi_capture.sv
// Self-checking bench for adc_multi_capture.
// Serial ADC model, cnv/sck monitor, packet expectations from conversion log.
module tb_adc_multi_capture;
  localparam int NCH = 2;
  localparam int DW  = 16;
  localparam int SD  = 2;
  localparam int CC  = 10;
  localparam int FD  = 4;
  localparam int CONV_LEN = CC + 2 * SD * DW + 1;

  logic        clk = 1'b0;
  logic        reset_p = 1'b1;
  logic        enable_p = 1'b0;
  logic        continuous_p = 1'b0;
  logic        trigger_p = 1'b0;
  logic [15:0] period = 16'd0;
  logic [1:0]  sdo;
  logic        cnv;
  logic        sck;
  logic        busy;

  adc_multi_capture_if #(.NUM_CH(NCH), .DATA_W(DW)) bus ();

  adc_multi_capture #(
    .NUM_CH(NCH), .DATA_W(DW), .SCK_DIV(SD),
    .CONV_CYC(CC), .FIFO_DEPTH(FD)
  ) dut (
    .clk210_p(clk),
    .reset_p(reset_p),
    .enable_p(enable_p),
    .continuous_p(continuous_p),
    .trigger_p(trigger_p),
    .sample_period_p(period),
    .sdo_p(sdo),
    .cnv_p(cnv),
    .sck_p(sck),
    .busy_p(busy),
    .rd_if(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0] words_q[$];
  logic [31:0] conv_log[$];
  logic [31:0] cur = 32'h0;
  int k = 16;

  always @(posedge cnv) begin
    cur = (words_q.size() > 0) ? words_q.pop_front() : 32'($urandom);
    conv_log.push_back(cur);
    k = 0;
  end
  always @(posedge sck) k++;
  assign sdo[0] = (k < 16) ? cur[15-k] : 1'b0;
  assign sdo[1] = (k < 16) ? cur[31-k] : 1'b0;

  int rise_t[$];
  int cnv_len[$];
  int sck_t[$];
  int cl = 0;
  int sck_bad = 0;
  logic pc = 1'b0;
  logic ps = 1'b0;

  always @(negedge clk) begin
    if (cnv === 1'b1 && !pc) rise_t.push_back(cyc);
    if (cnv === 1'b1) cl++;
    else if (pc) begin
      cnv_len.push_back(cl);
      cl = 0;
    end
    if (sck === 1'b1 && !ps) sck_t.push_back(cyc);
    if (sck === 1'b1 && cnv === 1'b1) sck_bad++;
    pc = (cnv === 1'b1);
    ps = (sck === 1'b1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    words_q.delete();
    conv_log.delete();
    rise_t.delete();
    cnv_len.delete();
    sck_t.delete();
    cl = 0;
    sck_bad = 0;
  endtask

  task automatic do_reset;
    reset_p = 1'b1;
    enable_p = 1'b0;
    continuous_p = 1'b0;
    trigger_p = 1'b0;
    bus.rd_req_p = 1'b0;
    tick;
    tick;
    reset_p = 1'b0;
    clear_mon;
  endtask

  task automatic rd_pkt(output logic [39:0] pkt, output logic acked);
    bus.rd_req_p = 1'b1;
    tick;
    acked = bus.rd_ack_p;
    pkt = bus.data_packet_p;
    bus.rd_req_p = 1'b0;
    tick;
  endtask

  task automatic wait_idle(input int lim, output logic ok);
    for (int i = 0; i < lim && busy; i++) tick;
    ok = !busy;
  endtask

  task automatic test_reset;
    bus.rd_req_p = 1'b0;
    reset_p = 1'b1;
    tick;
    tick;
    total++;
    if (cnv !== 1'b0) begin
      bad++; $display("FAIL reset_cnv got=%b exp=0", cnv);
    end
    total++;
    if (sck !== 1'b0) begin
      bad++; $display("FAIL reset_sck got=%b exp=0", sck);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    total++;
    if (bus.rd_ack_p !== 1'b0) begin
      bad++; $display("FAIL reset_ack got=%b exp=0", bus.rd_ack_p);
    end
    total++;
    if (bus.fifo_empty_p !== 1'b1 || bus.fifo_full_p !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags got empty=%b full=%b exp 1/0",
               bus.fifo_empty_p, bus.fifo_full_p);
    end
    total++;
    if (bus.overflow_cnt_p !== 8'd0) begin
      bad++; $display("FAIL reset_ovf got=%0d exp=0", bus.overflow_cnt_p);
    end
    total++;
    if (bus.data_packet_p !== 40'd0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", bus.data_packet_p);
    end
    reset_p = 1'b0;
    clear_mon;
  endtask

  task automatic test_empty_read;
    do_reset;
    bus.rd_req_p = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      total++;
      if (bus.rd_ack_p !== 1'b0) begin
        bad++; $display("FAIL empty_read_ack cyc=%0d got=%b exp=0", i, bus.rd_ack_p);
      end
    end
    bus.rd_req_p = 1'b0;
    total++;
    if (bus.fifo_empty_p !== 1'b1) begin
      bad++; $display("FAIL empty_read_flag got=%b exp=1", bus.fifo_empty_p);
    end
  endtask

  task automatic test_single;
    logic ok;
    logic ack;
    logic [39:0] pkt;
    int badsp;
    do_reset;
    words_q.push_back(32'h1234A5C3);
    enable_p = 1'b1;
    continuous_p = 1'b0;
    trigger_p = 1'b1;
    tick;
    trigger_p = 1'b0;
    total++;
    if (cnv !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL single_start got cnv=%b busy=%b exp 1/1", cnv, busy);
    end
    tick;
    tick;
    trigger_p = 1'b1;
    tick;
    trigger_p = 1'b0;
    wait_idle(300, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL single_timeout got busy=%b exp=0", busy);
    end
    for (int i = 0; i < 5; i++) tick;
    total++;
    if (rise_t.size() != 1) begin
      bad++; $display("FAIL single_rises got=%0d exp=1", rise_t.size());
    end
    total++;
    if (cnv_len.size() != 1 || cnv_len[0] != CC) begin
      bad++; $display("FAIL single_cnv_len got=%0d exp=%0d", cnv_len[0], CC);
    end
    total++;
    if (sck_t.size() != DW) begin
      bad++; $display("FAIL single_sck_rises got=%0d exp=%0d", sck_t.size(), DW);
    end
    badsp = 0;
    for (int i = 1; i < sck_t.size(); i++)
      if (sck_t[i] - sck_t[i-1] != 2 * SD) badsp++;
    total++;
    if (badsp != 0) begin
      bad++; $display("FAIL single_sck_period got=%0d bad gaps exp=0", badsp);
    end
    total++;
    if (sck_t[0] != rise_t[0] + CC + SD) begin
      bad++;
      $display("FAIL single_first_sck got=%0d exp=%0d", sck_t[0], rise_t[0] + CC + SD);
    end
    total++;
    if (sck_bad != 0) begin
      bad++; $display("FAIL single_sck_in_conv got=%0d exp=0", sck_bad);
    end
    total++;
    if (bus.fifo_empty_p !== 1'b0) begin
      bad++; $display("FAIL single_not_empty got=%b exp=0", bus.fifo_empty_p);
    end
    rd_pkt(pkt, ack);
    total++;
    if (ack !== 1'b1 || pkt !== 40'h00_1234_A5C3) begin
      bad++; $display("FAIL single_pkt got ack=%b pkt=%h exp 1/001234a5c3", ack, pkt);
    end
    total++;
    if (bus.fifo_empty_p !== 1'b1) begin
      bad++; $display("FAIL single_drained got=%b exp=1", bus.fifo_empty_p);
    end
  endtask

  task automatic test_continuous;
    logic ok;
    logic ack;
    logic [39:0] pkt;
    int badsp;
    do_reset;
    for (int i = 0; i < 6; i++) words_q.push_back(32'($urandom));
    period = 16'd200;
    continuous_p = 1'b1;
    enable_p = 1'b1;
    for (int i = 0; i < 1400 && rise_t.size() < 6; i++) tick;
    enable_p = 1'b0;
    wait_idle(300, ok);
    total++;
    if (!ok || rise_t.size() != 6) begin
      bad++; $display("FAIL cont_rises got=%0d idle=%b exp 6/1", rise_t.size(), ok);
    end
    badsp = 0;
    for (int i = 1; i < rise_t.size(); i++)
      if (rise_t[i] - rise_t[i-1] != 200) badsp++;
    total++;
    if (badsp != 0) begin
      bad++; $display("FAIL cont_period got=%0d bad gaps exp=0", badsp);
    end
    total++;
    if (bus.fifo_full_p !== 1'b1) begin
      bad++; $display("FAIL cont_full got=%b exp=1", bus.fifo_full_p);
    end
    total++;
    if (bus.overflow_cnt_p !== 8'd2) begin
      bad++; $display("FAIL cont_ovf got=%0d exp=2", bus.overflow_cnt_p);
    end
    for (int j = 0; j < FD; j++) begin
      rd_pkt(pkt, ack);
      total++;
      if (ack !== 1'b1 || pkt !== {8'(j), conv_log[j]}) begin
        bad++;
        $display("FAIL cont_read%0d got ack=%b pkt=%h exp=%h", j, ack, pkt,
                 {8'(j), conv_log[j]});
      end
    end
    rd_pkt(pkt, ack);
    total++;
    if (ack !== 1'b0 || bus.fifo_empty_p !== 1'b1) begin
      bad++; $display("FAIL cont_after_drain got ack=%b empty=%b exp 0/1", ack, bus.fifo_empty_p);
    end
  endtask

  task automatic test_period_zero;
    logic ok;
    logic ack;
    logic [39:0] pkt;
    int badsp;
    do_reset;
    period = 16'd0;
    continuous_p = 1'b1;
    enable_p = 1'b1;
    for (int i = 0; i < 400 && rise_t.size() < 3; i++) tick;
    enable_p = 1'b0;
    wait_idle(200, ok);
    total++;
    if (!ok || rise_t.size() != 3) begin
      bad++; $display("FAIL p0_rises got=%0d idle=%b exp 3/1", rise_t.size(), ok);
    end
    badsp = 0;
    for (int i = 1; i < rise_t.size(); i++)
      if (rise_t[i] - rise_t[i-1] != CONV_LEN) badsp++;
    total++;
    if (badsp != 0) begin
      bad++; $display("FAIL p0_spacing got=%0d bad gaps exp=0 (gap %0d)", badsp, CONV_LEN);
    end
    total++;
    if (bus.fifo_full_p !== 1'b0 || bus.overflow_cnt_p !== 8'd0) begin
      bad++;
      $display("FAIL p0_flags got full=%b ovf=%0d exp 0/0", bus.fifo_full_p, bus.overflow_cnt_p);
    end
    for (int j = 0; j < 3; j++) begin
      rd_pkt(pkt, ack);
      total++;
      if (ack !== 1'b1 || pkt !== {8'(j), conv_log[j]}) begin
        bad++;
        $display("FAIL p0_read%0d got ack=%b pkt=%h exp=%h", j, ack, pkt,
                 {8'(j), conv_log[j]});
      end
    end
  endtask

  task automatic test_enable_drop;
    logic ok;
    logic ack;
    logic [39:0] pkt;
    do_reset;
    period = 16'd200;
    continuous_p = 1'b1;
    enable_p = 1'b1;
    tick;
    tick;
    tick;
    enable_p = 1'b0;
    wait_idle(300, ok);
    for (int i = 0; i < 10; i++) tick;
    total++;
    if (!ok || busy !== 1'b0 || rise_t.size() != 1) begin
      bad++; $display("FAIL drop_idle got busy=%b rises=%0d exp 0/1", busy, rise_t.size());
    end
    rd_pkt(pkt, ack);
    total++;
    if (ack !== 1'b1 || pkt !== {8'd0, conv_log[0]}) begin
      bad++; $display("FAIL drop_pkt got ack=%b pkt=%h exp=%h", ack, pkt, {8'd0, conv_log[0]});
    end
    total++;
    if (bus.fifo_empty_p !== 1'b1) begin
      bad++; $display("FAIL drop_one_only got empty=%b exp=1", bus.fifo_empty_p);
    end
  endtask

  task automatic test_reset_shift;
    logic ok;
    do_reset;
    continuous_p = 1'b0;
    enable_p = 1'b1;
    trigger_p = 1'b1;
    tick;
    trigger_p = 1'b0;
    wait_idle(300, ok);
    total++;
    if (!ok || bus.fifo_empty_p !== 1'b0) begin
      bad++; $display("FAIL rs_pre got empty=%b exp=0", bus.fifo_empty_p);
    end
    trigger_p = 1'b1;
    tick;
    trigger_p = 1'b0;
    for (int i = 0; i < 200 && sck !== 1'b1; i++) tick;
    total++;
    if (sck !== 1'b1) begin
      bad++; $display("FAIL rs_shift_reach got sck=%b exp=1", sck);
    end
    reset_p = 1'b1;
    tick;
    total++;
    if (cnv !== 1'b0 || sck !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rs_ctrl got cnv=%b sck=%b busy=%b exp 0/0/0", cnv, sck, busy);
    end
    total++;
    if (bus.fifo_empty_p !== 1'b1 || bus.overflow_cnt_p !== 8'd0 ||
        bus.data_packet_p !== 40'd0) begin
      bad++;
      $display("FAIL rs_fifo got empty=%b ovf=%0d data=%h exp 1/0/0",
               bus.fifo_empty_p, bus.overflow_cnt_p, bus.data_packet_p);
    end
    reset_p = 1'b0;
    enable_p = 1'b0;
    tick;
    tick;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rs_stay_idle got busy=%b exp=0", busy);
    end
  endtask

  initial begin
    bus.rd_req_p = 1'b0;
    test_reset;
    test_empty_read;
    test_single;
    test_continuous;
    test_period_zero;
    test_enable_drop;
    test_reset_shift;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
